// File: rtl/phy_clk_sched.sv
// phy_clk_sched: clk_32f-synchronous rate scheduler for the PHY striping/serializer datapath.
// Latency: every output is registered; strobes line up with the cycle in which phase shows the
//          matching value, and mask changes take effect from phase 0 of the following frame.
// Backpressure: none on the datapath; reconfiguration uses a cfg_req/cfg_ack handshake and is
//          applied only on a 32-cycle frame boundary.
// Ports: clk_32f (sole clock), reset (async, active-high), enable (run/shutdown level),
//        cfg_req/cfg_mask/cfg_ack (mask reconfiguration), en_4f/en_2f/en_f (1/8, 1/16, 1/32 strobes),
//        frame_end (phase 31 pulse), phase (frame counter), active_mask {f,2f,4f}, ready (RUN only),
//        state (IDLE=0, SETTLE=1, RUN=2, DRAIN=3).
// Optional: define PHY_CLK_SQUARE_OUT_EN to add clk_4f_o/clk_2f_o/clk_f_o 50% square outputs.
module phy_clk_sched #(
   parameter int         SETTLE_CYCLES = 64,
   parameter logic [2:0] INIT_MASK     = 3'b111
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic       enable,
   input  logic       cfg_req,
   input  logic [2:0] cfg_mask,
   output logic       cfg_ack,
   output logic       en_4f,
   output logic       en_2f,
   output logic       en_f,
   output logic       frame_end,
   output logic [4:0] phase,
   output logic [2:0] active_mask,
   output logic       ready,
   output logic [1:0] state
`ifdef PHY_CLK_SQUARE_OUT_EN
   ,
   output logic       clk_4f_o,
   output logic       clk_2f_o,
   output logic       clk_f_o
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

   state_t     st, st_n;
   logic [7:0] cnt, cnt_n;
   logic [4:0] phase_n;
   logic [2:0] mask_n;
   logic       seen, seen_n;
   logic       pend, pend_n;
   logic       drain_first, drain_first_n;
   logic       ack_n;
   logic       accept;
   logic       counting_n;

   assign state = st;

   always_comb begin
      st_n          = st;
      cnt_n         = cnt;
      phase_n       = phase;
      mask_n        = active_mask;
      pend_n        = pend;
      ack_n         = 1'b0;
      drain_first_n = 1'b0;
      // Requests are taken only in RUN; a request raised during DRAIN or SETTLE
      // waits (still high, flag still clear) until the scheduler is back in RUN.
      accept        = cfg_req & ~seen & (st == RUN);
      seen_n        = cfg_req & (seen | accept);
      case (st)
         IDLE: begin
            phase_n = 5'd0;
            if (enable) begin
               st_n   = SETTLE;
               mask_n = INIT_MASK;
               cnt_n  = 8'd0;
            end
         end
         SETTLE: begin
            if (!enable) begin
               st_n   = IDLE;
               mask_n = 3'b000;
            end else if (cnt == SETTLE_LAST) begin
               st_n    = RUN;
               phase_n = 5'd0;
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         RUN: begin
            phase_n = phase + 5'd1;
            if (accept) pend_n = 1'b1;
            if (!enable || accept) begin
               st_n          = DRAIN;
               drain_first_n = 1'b1;
            end
         end
         DRAIN: begin
            phase_n = phase + 5'd1;
            // The entry cycle never counts as the boundary, so a drain entered
            // at phase 31 runs one full extra frame.
            if (phase == 5'd31 && !drain_first) begin
               if (!enable) begin
                  st_n   = IDLE;
                  mask_n = 3'b000;
                  pend_n = 1'b0;
               end else begin
                  st_n = RUN;
                  if (pend) begin
                     mask_n = cfg_mask;
                     ack_n  = 1'b1;
                     pend_n = 1'b0;
                  end
               end
            end
         end
         default: st_n = IDLE;
      endcase
      counting_n = (st_n == RUN) || (st_n == DRAIN);
   end

   // Strobes are computed from next-cycle phase/mask so they appear together
   // with the phase value they decode.
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         st          <= IDLE;
         cnt         <= 8'd0;
         phase       <= 5'd0;
         active_mask <= 3'b000;
         seen        <= 1'b0;
         pend        <= 1'b0;
         drain_first <= 1'b0;
         cfg_ack     <= 1'b0;
         en_4f       <= 1'b0;
         en_2f       <= 1'b0;
         en_f        <= 1'b0;
         frame_end   <= 1'b0;
         ready       <= 1'b0;
      end else begin
         st          <= st_n;
         cnt         <= cnt_n;
         phase       <= phase_n;
         active_mask <= mask_n;
         seen        <= seen_n;
         pend        <= pend_n;
         drain_first <= drain_first_n;
         cfg_ack     <= ack_n;
         en_4f       <= counting_n & mask_n[0] & (phase_n[2:0] == 3'd7);
         en_2f       <= counting_n & mask_n[1] & (phase_n[3:0] == 4'd15);
         en_f        <= counting_n & mask_n[2] & (phase_n == 5'd31);
         frame_end   <= counting_n & (phase_n == 5'd31);
         ready       <= (st_n == RUN);
      end
   end

`ifdef PHY_CLK_SQUARE_OUT_EN
   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         clk_4f_o <= 1'b0;
         clk_2f_o <= 1'b0;
         clk_f_o  <= 1'b0;
      end else begin
         clk_4f_o <= counting_n & mask_n[0] & phase_n[2];
         clk_2f_o <= counting_n & mask_n[1] & phase_n[3];
         clk_f_o  <= counting_n & mask_n[2] & phase_n[4];
      end
   end
`endif

endmodule

// File: tb/tb_phy_clk_sched.sv
// tb_phy_clk_sched: directed scenarios plus randomized enable/request traffic for phy_clk_sched,
// checked every cycle against a frame-level behavioural model.
module tb_phy_clk_sched;
   localparam int         SC = 4;
   localparam logic [2:0] IM = 3'b111;

   logic       clk_32f = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       cfg_req = 1'b0;
   logic [2:0] cfg_mask = 3'b000;
   logic       cfg_ack, en_4f, en_2f, en_f, frame_end, ready;
   logic [4:0] phase;
   logic [2:0] active_mask;
   logic [1:0] state;
`ifdef PHY_CLK_SQUARE_OUT_EN
   logic       clk_4f_o, clk_2f_o, clk_f_o;
`endif

   phy_clk_sched #(.SETTLE_CYCLES(SC), .INIT_MASK(IM)) dut (
      .clk_32f(clk_32f), .reset(reset), .enable(enable), .cfg_req(cfg_req), .cfg_mask(cfg_mask),
      .cfg_ack(cfg_ack), .en_4f(en_4f), .en_2f(en_2f), .en_f(en_f), .frame_end(frame_end),
      .phase(phase), .active_mask(active_mask), .ready(ready), .state(state)
`ifdef PHY_CLK_SQUARE_OUT_EN
      , .clk_4f_o(clk_4f_o), .clk_2f_o(clk_2f_o), .clk_f_o(clk_f_o)
`endif
   );

   always #5 clk_32f = ~clk_32f;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model: state 0..3, phase as an integer, drain age in cycles.
   int       m_st, m_phase, m_cnt, m_dc;
   bit [2:0] m_mask;
   bit       m_seen, m_pend, m_ack;

   task automatic model_reset();
      m_st = 0; m_phase = 0; m_cnt = 0; m_dc = 0;
      m_mask = 3'b000; m_seen = 0; m_pend = 0; m_ack = 0;
   endtask

   task automatic model_step(input bit en, input bit req, input bit [2:0] cm);
      bit acc, boundary;
      acc = (m_st == 2) && req && !m_seen;
      m_ack = 0;
      case (m_st)
         0: begin
            m_phase = 0;
            if (en) begin m_st = 1; m_mask = IM; m_cnt = 0; end
         end
         1: begin
            if (!en) begin m_st = 0; m_mask = 0; end
            else if (m_cnt == SC - 1) begin m_st = 2; m_phase = 0; end
            else m_cnt++;
         end
         2: begin
            m_phase = (m_phase + 1) % 32;
            if (acc) m_pend = 1;
            if (!en || acc) begin m_st = 3; m_dc = 0; end
         end
         default: begin
            boundary = (m_phase == 31) && (m_dc > 0);
            m_phase = (m_phase + 1) % 32;
            m_dc++;
            if (boundary) begin
               if (!en) begin m_st = 0; m_mask = 0; m_pend = 0; end
               else begin
                  m_st = 2;
                  if (m_pend) begin m_mask = cm; m_ack = 1; m_pend = 0; end
               end
            end
         end
      endcase
      m_seen = req && (m_seen || acc);
   endtask

   function automatic logic [31:0] model_vec();
      bit run;
      logic [31:0] v;
      run = (m_st == 2) || (m_st == 3);
      v = {16'd0, 2'(m_st), 5'(m_phase), m_mask, (m_st == 2), m_ack,
           run && m_mask[0] && (m_phase % 8 == 7),
           run && m_mask[1] && (m_phase % 16 == 15),
           run && m_mask[2] && (m_phase == 31),
           run && (m_phase == 31)};
`ifdef PHY_CLK_SQUARE_OUT_EN
      v = {v[28:0], run && m_mask[0] && ((m_phase / 4) % 2 == 1),
                    run && m_mask[1] && ((m_phase / 8) % 2 == 1),
                    run && m_mask[2] && (m_phase >= 16)};
`endif
      return v;
   endfunction

   function automatic logic [31:0] dut_vec();
      logic [31:0] v;
      v = {16'd0, state, phase, active_mask, ready, cfg_ack, en_4f, en_2f, en_f, frame_end};
`ifdef PHY_CLK_SQUARE_OUT_EN
      v = {v[28:0], clk_4f_o, clk_2f_o, clk_f_o};
`endif
      return v;
   endfunction

   int c4, c2, cf, cfe, cack, csq_hi, csq_rise;
   logic sq_prev = 1'b0;

   task automatic clr_counts();
      c4 = 0; c2 = 0; cf = 0; cfe = 0; cack = 0; csq_hi = 0; csq_rise = 0;
   endtask

   task automatic cycle(input logic en, input logic req, input logic [2:0] cm);
      enable = en; cfg_req = req; cfg_mask = cm;
      @(posedge clk_32f);
      model_step(en, req, cm);
      @(negedge clk_32f);
      check("cycle_outputs", dut_vec(), model_vec());
      c4 += int'(en_4f); c2 += int'(en_2f); cf += int'(en_f);
      cfe += int'(frame_end); cack += int'(cfg_ack);
`ifdef PHY_CLK_SQUARE_OUT_EN
      csq_hi += int'(clk_f_o);
      if (clk_f_o && !sq_prev) csq_rise++;
      sq_prev = clk_f_o;
`endif
   endtask

   task automatic run_until_phase(input int p);
      int k;
      for (k = 0; k < 70 && !(m_st == 2 && m_phase == p); k++) cycle(1, 0, 3'b000);
      if (k == 70) check("timeout_phase", 0, 1);
   endtask

   task automatic startup();
      int k, ns;
      ns = 0;
      for (k = 0; k < 20 && m_st != 2; k++) begin
         cycle(1, 0, 3'b000);
         if (state == 2'd1) ns++;
      end
      check("settle_cycles", ns, SC);
      check("run_phase0", phase, 0);
      check("run_ready", ready, 1);
   endtask

   initial begin
      logic rq, acked, en_r;
      logic [2:0] msk;
      model_reset();
      clr_counts();
      repeat (2) @(posedge clk_32f);
      @(negedge clk_32f);
      check("reset_outputs", dut_vec(), 0);
      reset = 1'b0;

      startup();

      // strobe cadence over two full frames with all domains active
      clr_counts();
      repeat (64) cycle(1, 0, 3'b000);
      check("cnt_4f", c4, 8);
      check("cnt_2f", c2, 4);
      check("cnt_f", cf, 2);
      check("cnt_frame_end", cfe, 2);
`ifdef PHY_CLK_SQUARE_OUT_EN
      check("sq_f_high", csq_hi, 32);
      check("sq_f_rise", csq_rise, 2);
`endif

      // asynchronous reset mid-RUN must clear outputs before the next edge
      run_until_phase(12);
      #2 reset = 1'b1;
      #1 check("async_reset", dut_vec(), 0);
      model_reset();
      @(negedge clk_32f);
      reset = 1'b0;
      startup();

      // reconfiguration to {2f} only
      run_until_phase(5);
      clr_counts();
      for (int k = 0; k < 70 && !m_ack; k++) cycle(1, 1, 3'b010);
      check("reconf_ack_once", cack, 1);
      check("reconf_mask", active_mask, 3'b010);
      check("reconf_phase", phase, 0);
      clr_counts();
      repeat (40) cycle(1, 1, 3'b010);
      check("held_req_no_ack", cack, 0);
      check("masked_4f", c4, 0);
      check("masked_f", cf, 0);
      check("only_2f", c2, 2);
      cycle(1, 0, 3'b000);

      // shutdown and request in the same cycle: shutdown wins
      run_until_phase(10);
      clr_counts();
      for (int k = 0; k < 70 && m_st != 0; k++) cycle(0, 1, 3'b001);
      check("shutdown_no_ack", cack, 0);
      check("shutdown_mask", active_mask, 0);
      check("shutdown_state", state, 0);
      cycle(0, 0, 3'b000);
      startup();

      // cancelled shutdown
      run_until_phase(3);
      clr_counts();
      for (int k = 0; k < 70 && m_phase != 20; k++) cycle(0, 0, 3'b000);
      for (int k = 0; k < 70 && m_st != 2; k++) cycle(1, 0, 3'b000);
      check("cancel_state", state, 2);
      check("cancel_mask", active_mask, IM);
      check("cancel_no_ack", cack, 0);

      // randomized traffic
      rq = 0; acked = 0; en_r = 1; msk = 3'b000;
      for (int k = 0; k < 4000; k++) begin
         if (en_r && $urandom_range(0, 199) == 0) en_r = 0;
         else if (!en_r && $urandom_range(0, 29) == 0) en_r = 1;
         if (!rq && $urandom_range(0, 19) == 0) begin
            rq = 1; acked = 0; msk = 3'($urandom);
         end else if (rq && (acked || m_st == 0) && $urandom_range(0, 3) == 0) begin
            rq = 0;
         end
         cycle(en_r, rq, msk);
         if (m_ack) acked = 1;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
